rptr_empty_fwft: RTL



---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/gray2bin.sv | 17 +
 rtl/rptr_empty_fwft.sv | 117 +++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async FIFO pointer/flag blocks.
package async_fifo_pkg;

    // Output stage modes for the read-side pointer block.
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width (Gray or binary) for a given memory address width;
    // the extra MSB distinguishes full from empty on wrap.
    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-domain pointer, empty/almost-empty/level/underflow flags, with an
// optional first-word-fall-through output register.
module rptr_empty_fwft
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8,
    parameter int FWFT     = FIFO_STD
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rinc,
    input  logic [ADDRSIZE:0]     rq2_wptr,
    input  logic [ADDRSIZE:0]     raempty_thresh,
    input  logic                  runderflow_clr,
    input  logic [DATASIZE-1:0]   rmem_data,
    output logic [ADDRSIZE-1:0]   raddr,
    output logic [ADDRSIZE:0]     rptr,
    output logic [DATASIZE-1:0]   rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  raempty,
    output logic [ADDRSIZE:0]     rlevel,
    output logic                  runderflow
);

    localparam int  PW      = ptr_width(ADDRSIZE);
    localparam bit  IS_FWFT = (FWFT == FIFO_FWFT);

    logic [PW-1:0]       rbin_q, rbin_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic                mem_empty_q, mem_empty_d;
    logic                rvalid_q, rvalid_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic [PW-1:0]       rlevel_q, rlevel_d;
    logic                raempty_q, raempty_d;
    logic                runderflow_q, runderflow_d;

    logic [PW-1:0]       wbin_sync;
    logic                pop;
    logic                consumer_empty;

    gray2bin #(
        .WIDTH (PW)
    ) u_gray2bin (
        .gray (rq2_wptr),
        .bin  (wbin_sync)
    );

    // Next-state: pop decision, pointer advance, head register and flags.
    always_comb begin
        consumer_empty = IS_FWFT ? ~rvalid_q : mem_empty_q;

        // In FWFT mode the head register refills whenever it is empty or
        // being consumed, so one word per cycle is sustained.
        if (IS_FWFT) begin
            pop = ~mem_empty_q & (~rvalid_q | rinc);
        end else begin
            pop = rinc & ~mem_empty_q;
        end

        rbin_d      = rbin_q + PW'(pop);
        rptr_d      = (rbin_d >> 1) ^ rbin_d;
        mem_empty_d = (rptr_d == rq2_wptr);

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (IS_FWFT) begin
            if (pop) begin
                rdata_d  = rmem_data;
                rvalid_d = 1'b1;
            end else if (rinc && rvalid_q) begin
                rvalid_d = 1'b0;
            end
        end

        // The word held in the head register still counts as occupancy.
        rlevel_d  = wbin_sync - rbin_d + (IS_FWFT ? PW'(rvalid_d) : PW'(0));
        raempty_d = (rlevel_d <= raempty_thresh);

        // Set has priority over clear.
        runderflow_d = (rinc & consumer_empty) | (runderflow_q & ~runderflow_clr);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            mem_empty_q  <= 1'b1;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rlevel_q     <= '0;
            raempty_q    <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            mem_empty_q  <= mem_empty_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rlevel_q     <= rlevel_d;
            raempty_q    <= raempty_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr      = rbin_q[ADDRSIZE-1:0];
    assign rptr       = rptr_q;
    assign rdata      = IS_FWFT ? rdata_q : rmem_data;
    assign rvalid     = IS_FWFT ? rvalid_q : ~mem_empty_q;
    assign rempty     = consumer_empty;
    assign raempty    = raempty_q;
    assign rlevel     = rlevel_q;
    assign runderflow = runderflow_q;

endmodule
